// File: rtl/sync_fifo_ft.sv
// rtl/sync_fifo_ft.sv - single-clock FIFO with exact count, programmable thresholds, FWFT option and sticky errors
module sync_fifo_ft #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   af_thresh,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                err_clr,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int                DEPTH   = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE + 1)'(DEPTH);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                wfull_q, wfull_d;
  logic                rempty_q, rempty_d;
  logic                af_q, af_d;
  logic                ae_q, ae_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_en, rd_en;

  // Accepts are gated only by the registered flags, so a pop never frees room for a same-cycle push.
  assign wr_en = winc & ~wfull_q & ~rst;
  assign rd_en = rinc & ~rempty_q & ~rst;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      wptr_d = wptr_q + ADDRSIZE'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + ADDRSIZE'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + (ADDRSIZE + 1)'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - (ADDRSIZE + 1)'(1);
    end

    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    af_d     = (count_d >= af_thresh);
    ae_d     = (count_d <= ae_thresh);

    // Set wins over clear so an error coinciding with err_clr is never lost.
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (winc && wfull_q) begin
      ovf_d = 1'b1;
    end
    if (rinc && rempty_q) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata  = mem_q[rptr_q];
      assign rvalid = ~rempty_q;
    end else begin : g_std
      logic [DATASIZE-1:0] rdata_q, rdata_d;
      logic                rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_en;
        if (rd_en) begin
          rdata_d = mem_q[rptr_q];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ft.sv
// tb/tb_sync_fifo_ft.sv - directed bench for sync_fifo_ft in standard and FWFT modes
module tb_sync_fifo_ft;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdata;
  logic       s_winc, s_rinc, f_winc, f_rinc;
  logic [4:0] af_thresh, ae_thresh;
  logic       err_clr;

  logic [7:0] s_rdata, f_rdata;
  logic       s_rvalid, s_wfull, s_rempty, s_af, s_ae, s_ovf, s_unf;
  logic       f_rvalid, f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_ft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(s_winc), .rinc(s_rinc),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
    .rdata(s_rdata), .rvalid(s_rvalid), .wfull(s_wfull), .rempty(s_rempty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) u_ft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(f_winc), .rinc(f_rinc),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
    .rdata(f_rdata), .rvalid(f_rvalid), .wfull(f_wfull), .rempty(f_rempty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wdata = 8'h77; s_winc = 1'b1; s_rinc = 1'b0; f_winc = 1'b0; f_rinc = 1'b0;
    af_thresh = 5'd12; ae_thresh = 5'd3; err_clr = 1'b0;
    step(); step();
    chk("rst_count", s_count, 0);
    chk("rst_rempty", s_rempty, 1);
    chk("rst_ae", s_ae, 1);
    chk("rst_wfull", s_wfull, 0);
    chk("rst_af", s_af, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_unf", s_unf, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    rst = 1'b0; s_winc = 1'b0;

    // fill 0x00..0x0F, thresholds 12 / 3
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i); s_winc = 1'b1;
      step();
      chk("fill_count", s_count, i + 1);
      chk("fill_af", s_af, (i + 1 >= 12) ? 1 : 0);
      chk("fill_ae", s_ae, (i + 1 <= 3) ? 1 : 0);
      chk("fill_wfull", s_wfull, (i == 15) ? 1 : 0);
    end
    wdata = 8'hAA;
    step();
    chk("ovf_count", s_count, 16);
    chk("ovf_set", s_ovf, 1);
    s_winc = 1'b0;

    for (int i = 0; i < 16; i++) begin
      s_rinc = 1'b1;
      step();
      chk("drain_rdata", s_rdata, i);
      chk("drain_rvalid", s_rvalid, 1);
      chk("drain_count", s_count, 15 - i);
      chk("drain_af", s_af, (15 - i >= 12) ? 1 : 0);
      chk("drain_ae", s_ae, (15 - i <= 3) ? 1 : 0);
    end
    chk("drain_rempty", s_rempty, 1);
    step();
    chk("unf_set", s_unf, 1);
    chk("unf_rvalid", s_rvalid, 0);
    chk("unf_rdata_hold", s_rdata, 8'h0F);
    chk("unf_count", s_count, 0);
    s_rinc = 1'b0; err_clr = 1'b1;
    step();
    chk("clr_ovf", s_ovf, 0);
    chk("clr_unf", s_unf, 0);
    err_clr = 1'b0;

    // simultaneous ops while full
    s_winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(8'h10 + i);
      step();
    end
    chk("full2_count", s_count, 16);
    wdata = 8'hBB; s_rinc = 1'b1;
    step();
    chk("full_rw_count", s_count, 15);
    chk("full_rw_ovf", s_ovf, 1);
    chk("full_rw_rdata", s_rdata, 8'h10);
    chk("full_rw_wfull", s_wfull, 0);
    s_rinc = 1'b0; wdata = 8'h20; af_thresh = 5'd17;
    step();
    chk("af17_count", s_count, 16);
    chk("af17_af", s_af, 0);
    af_thresh = 5'd12; err_clr = 1'b1;
    step();
    chk("clr_vs_set_ovf", s_ovf, 1);
    chk("af12_af", s_af, 1);
    s_winc = 1'b0;
    step();
    chk("clr_ovf2", s_ovf, 0);
    err_clr = 1'b0;

    q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
         8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20};
    s_rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_d = q.pop_front();
      step();
      chk("pop8_rdata", s_rdata, exp_d);
    end
    chk("pop8_count", s_count, 8);
    s_winc = 1'b1; wdata = 8'hCC;
    step();
    chk("mid_rw_count", s_count, 8);
    chk("mid_rw_rdata", s_rdata, 8'h19);
    void'(q.pop_front());
    q.push_back(8'hCC);
    s_winc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = q.pop_front();
      step();
      chk("mid_drain_rdata", s_rdata, exp_d);
    end
    chk("mid_drain_last", s_rdata, 8'hCC);
    chk("mid_drain_rempty", s_rempty, 1);
    s_rinc = 1'b0;

    // reset at count 9 with a coincident write
    s_winc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = 8'(8'h80 + i);
      step();
    end
    chk("pre_rst_count", s_count, 9);
    rst = 1'b1; wdata = 8'hEE;
    step();
    chk("mid_rst_count", s_count, 0);
    chk("mid_rst_rempty", s_rempty, 1);
    chk("mid_rst_ae", s_ae, 1);
    chk("mid_rst_wfull", s_wfull, 0);
    rst = 1'b0; s_winc = 1'b0;
    step();
    chk("post_rst_count", s_count, 0);
    chk("post_rst_rempty", s_rempty, 1);

    // pointer wrap: occupancy kept at 3..4
    q = {};
    s_winc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'(8'h30 + i);
      q.push_back(wdata);
      step();
    end
    for (int j = 0; j < 40; j++) begin
      s_winc = (j % 4 != 2);
      s_rinc = (j % 4 != 0);
      wdata  = 8'(8'h40 + j);
      exp_d  = 8'h00;
      if (s_rinc) exp_d = q.pop_front();
      if (s_winc) q.push_back(wdata);
      step();
      if (s_rinc) chk("wrap_rdata", s_rdata, exp_d);
      chk("wrap_count", s_count, q.size());
    end
    s_winc = 1'b0; s_rinc = 1'b0;

    // first-word-fall-through
    wdata = 8'h5A; f_winc = 1'b1;
    step();
    chk("fwft_rdata", f_rdata, 8'h5A);
    chk("fwft_rvalid", f_rvalid, 1);
    chk("fwft_count", f_count, 1);
    f_winc = 1'b0;
    step();
    chk("fwft_hold_rvalid", f_rvalid, 1);
    f_rinc = 1'b1;
    step();
    chk("fwft_pop_rvalid", f_rvalid, 0);
    chk("fwft_pop_rempty", f_rempty, 1);
    f_rinc = 1'b0; f_winc = 1'b1; wdata = 8'h61;
    step();
    wdata = 8'h62;
    step();
    chk("fwft_two_rdata", f_rdata, 8'h61);
    f_winc = 1'b0; f_rinc = 1'b1;
    step();
    chk("fwft_next_rdata", f_rdata, 8'h62);
    chk("fwft_next_rvalid", f_rvalid, 1);
    f_rinc = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ft.md
# sync_fifo_ft

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for blocks living entirely in one clock domain. It adds:

- an exact occupancy count;
- run-time programmable almost-full and almost-empty thresholds;
- selectable standard or first-word-fall-through (FWFT) read mode;
- sticky overflow and underflow error flags with software clear.

It sits between same-clock producer/consumer pipelines, such as datapath stage decoupling and register-file command queues.

## Interface
Parameters:
- DATASIZE, 8, data word width
- ADDRSIZE, 4, address width; DEPTH = 1<<ADDRSIZE entries
- FWFT, 0, 0 = standard read with 1-cycle latency, 1 = first-word-fall-through

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wdata  input  DATASIZE  write data
- winc  input  1  write request
- rinc  input  1  read/pop request
- af_thresh  input  ADDRSIZE+1  almost-full threshold
- ae_thresh  input  ADDRSIZE+1  almost-empty threshold
- err_clr  input  1  clears overflow/underflow
- rdata  output  DATASIZE  read data
- rvalid  output  1  rdata valid
- wfull  output  1  FIFO holds DEPTH words
- rempty  output  1  FIFO holds 0 words
- almost_full  output  1  count >= af_thresh
- almost_empty  output  1  count <= ae_thresh
- count  output  ADDRSIZE+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATASIZE register array. The array is not reset.
- Pointers: ADDRSIZE-bit binary wptr and rptr. Each wraps DEPTH-1 -> 0 naturally.
- Occupancy: count register, ADDRSIZE+1 bits.
- Write accept: wr_en = winc & ~wfull. Read accept: rd_en = rinc & ~rempty.
- Count update:
  - count_next = count + wr_en - rd_en.
  - Simultaneous wr_en and rd_en leaves count unchanged; both pointers advance.
- Flag sources:
  - wfull, rempty, almost_full and almost_empty are registers computed from count_next and the current thresholds.
  - They are therefore consistent with count on every cycle.
- Full/empty gating:
  - A write while wfull=1 is dropped, even if rd_en is active in the same cycle.
  - A read while rempty=1 is dropped, even if winc is active in the same cycle.
- Threshold ranges:
  - af_thresh = 0 makes almost_full = 1 from the first cycle after reset.
  - af_thresh > DEPTH means almost_full never asserts.
  - ae_thresh >= DEPTH means almost_empty is always 1.
- Error flags:
  - overflow is set on winc & wfull; underflow is set on rinc & rempty.
  - Both hold until err_clr or rst.
  - Set has priority over err_clr in the same cycle.
- Standard mode (FWFT=0):
  - On rd_en, rdata <= mem[rptr] and rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds its last value.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally; rvalid = ~rempty.
  - rinc pops the displayed word.
- Reset values (any cycle with rst=1):
  - Pointers and count = 0.
  - rempty = 1, almost_empty = 1, wfull = 0, almost_full = 0.
  - overflow = 0, underflow = 0.
  - rvalid = 0; rdata = 0 in standard mode.
  - winc and rinc are ignored while rst=1.
  - Reset mid-operation discards all contents; no data are recovered.

## Timing
- Write sampled at edge k: the word is stored and count/flags update at edge k.
- Standard mode:
  - Earliest pop of that word is rinc at edge k+1.
  - rdata/rvalid are valid after edge k+1, so write-to-data latency is 2 edges.
- FWFT mode:
  - rdata is valid after edge k, so write-to-data latency is 1 edge.
- Full-throughput steady state: one write and one read per cycle with no bubbles when 0 < count < DEPTH.
- Changes on af_thresh/ae_thresh are reflected in the flags after the next edge.
- Reset is deasserted at edge r; the first write is accepted at edge r+1.

## Test plan
- Fill/drain (DEPTH=16, FWFT=0):
  - Write 0x00..0x0F on consecutive cycles: wfull=1 and count=16 after the 16th edge.
  - 17th write of 0xAA: dropped, overflow=1.
  - Drain: rdata sequence 0x00..0x0F, each with rvalid=1.
  - rempty=1 after the 16th pop.
  - An extra rinc sets underflow.
- Simultaneous ops:
  - At count=16, winc+rinc together: read occurs, write dropped, count=15, overflow=1.
  - At count=8, winc+rinc together: count stays 8; data order preserved.
- Thresholds:
  - af_thresh=12, ae_thresh=3.
  - almost_full rises with count 12 and falls at 11.
  - almost_empty is 1 at count<=3 and 0 at 4.
  - Change af_thresh to 17: almost_full=0 at count 16.
- FWFT=1:
  - Write 0x5A at edge k: rdata=0x5A and rvalid=1 after edge k, with no rinc.
  - rinc pops; rvalid falls after the pop edge.
- Pointer wrap:
  - Run 40 interleaved writes/reads with count between 1 and 5.
  - Data order intact across wrap; count is never out of 0..16.
- Reset and error clear:
  - rst at count=9: count=0, rempty=1, almost_empty=1 after that edge.
  - A winc asserted in the same cycle as rst is ignored.
  - err_clr clears overflow; overflow re-asserts if err_clr coincides with winc&wfull.
